// File: rtl/imm_encoder.sv
// Encodes an immediate into a RISC-V instruction template, or splits a wide I-type immediate into LUI+ADDI.
// Latency: a request accepted at edge N appears on out_* after edge N; one word per cycle when out_ready=1.
// Backpressure: out_* hold while out_ready=0; in_ready follows out_ready for a single held word and is 0 while LUI waits.

`ifndef IMM_I
`define IMM_I 5'd1
`define IMM_S 5'd2
`define IMM_B 5'd3
`define IMM_J 5'd4
`define IMM_U 5'd5
`endif

module imm_encoder #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_sext_ope,
    input  logic [31:0] in_base,
    input  logic        in_split,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);

    // IDLE: nothing held; ONE: single word; HI: LUI held with ADDI pending; LO: ADDI held
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_err_q, out_err_d;
    logic        out_last_q, out_last_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] lo_imm_q, lo_imm_d;

    logic [31:0] enc_inst;
    logic        enc_ok;
    logic        do_split;
    logic        in_fire;
    logic [19:0] lui_upper;
    logic [31:0] lui_inst;
    logic [31:0] addi_inst;

    // Overwrite the immediate-owned fields of the template and check representability
    always_comb begin
        enc_inst = in_base;
        enc_ok   = 1'b1;
        case (in_sext_ope)
            `IMM_I: begin
                enc_inst[31:20] = in_imm[11:0];
                enc_ok          = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            `IMM_S: begin
                enc_inst[31:25] = in_imm[11:5];
                enc_inst[11:7]  = in_imm[4:0];
                enc_ok          = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            `IMM_B: begin
                enc_inst[31]    = in_imm[12];
                enc_inst[30:25] = in_imm[10:5];
                enc_inst[11:8]  = in_imm[4:1];
                enc_inst[7]     = in_imm[11];
                enc_ok          = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
            end
            `IMM_J: begin
                enc_inst[31]    = in_imm[20];
                enc_inst[30:21] = in_imm[10:1];
                enc_inst[20]    = in_imm[11];
                enc_inst[19:12] = in_imm[19:12];
                enc_ok          = ~in_imm[0] & ((&in_imm[31:20]) | ~(|in_imm[31:20]));
            end
            `IMM_U: begin
                enc_inst[31:12] = in_imm[31:12];
                enc_ok          = ~(|in_imm[11:0]);
            end
            default: begin
                enc_ok = 1'b0;
            end
        endcase
    end

    // LUI rounds up by imm[11] so that the sign-extended ADDI lands on the exact value
    always_comb begin
        do_split  = (in_sext_ope == `IMM_I) && !enc_ok && in_split && SPLIT_EN;
        lui_upper = in_imm[31:12] + {19'd0, in_imm[11]};
        lui_inst  = {lui_upper, in_base[11:7], 7'b0110111};
        addi_inst = {lo_imm_q, rd_q, 3'b000, rd_q, 7'b0010011};
    end

    // Accept whenever the held word leaves this cycle, or nothing is held
    always_comb begin
        case (state_q)
            IDLE:    in_ready = 1'b1;
            ONE, LO: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        in_fire = in_valid & in_ready;
    end

    // Next state and next output word
    always_comb begin
        state_d    = state_q;
        out_inst_d = out_inst_q;
        out_err_d  = out_err_q;
        out_last_d = out_last_q;
        rd_d       = rd_q;
        lo_imm_d   = lo_imm_q;
        if (in_fire) begin
            if (do_split) begin
                state_d    = HI;
                out_inst_d = lui_inst;
                out_err_d  = 1'b0;
                out_last_d = 1'b0;
                rd_d       = in_base[11:7];
                lo_imm_d   = in_imm[11:0];
            end else begin
                state_d    = ONE;
                out_inst_d = enc_inst;
                out_err_d  = ~enc_ok;
                out_last_d = 1'b1;
            end
        end else begin
            case (state_q)
                HI: begin
                    if (out_ready) begin
                        state_d    = LO;
                        out_inst_d = addi_inst;
                        out_err_d  = 1'b0;
                        out_last_d = 1'b1;
                    end
                end
                ONE, LO: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset discards any pending ADDI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_inst_q <= 32'd0;
            out_err_q  <= 1'b0;
            out_last_q <= 1'b0;
            rd_q       <= 5'd0;
            lo_imm_q   <= 12'd0;
        end else begin
            state_q    <= state_d;
            out_inst_q <= out_inst_d;
            out_err_q  <= out_err_d;
            out_last_q <= out_last_d;
            rd_q       <= rd_d;
            lo_imm_q   <= lo_imm_d;
        end
    end

    assign out_valid = (state_q != IDLE);
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: two instances (expansion enabled / disabled) against a queue-based reference model.
// Latency: model predicts words one cycle after accept.
// Backpressure: exercised with held and randomised out_ready.

`ifndef IMM_I
`define IMM_I 5'd1
`define IMM_S 5'd2
`define IMM_B 5'd3
`define IMM_J 5'd4
`define IMM_U 5'd5
`endif

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [31:0] in_imm = 32'd0;
    logic [4:0]  in_sext_ope = 5'd0;
    logic [31:0] in_base = 32'd0;
    logic        in_split = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_rdy;
    logic [1:0]  out_vld;
    logic [1:0]  out_e;
    logic [1:0]  out_l;
    logic [31:0] out_inst [2];

    int n_checks = 0;
    int n_errors = 0;
    bit rand_rdy = 1'b0;

    // reference model: per instance, list of words still to be emitted, each {inst, err, last}
    int          cnt [2];
    logic [33:0] q [2][2];

    always #5 clk = ~clk;

    imm_encoder #(.SPLIT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_rdy[0]),
        .in_imm(in_imm), .in_sext_ope(in_sext_ope), .in_base(in_base), .in_split(in_split),
        .out_valid(out_vld[0]), .out_ready(out_ready), .out_inst(out_inst[0]),
        .out_err(out_e[0]), .out_last(out_l[0])
    );

    imm_encoder #(.SPLIT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_rdy[1]),
        .in_imm(in_imm), .in_sext_ope(in_sext_ope), .in_base(in_base), .in_split(in_split),
        .out_valid(out_vld[1]), .out_ready(out_ready), .out_inst(out_inst[1]),
        .out_err(out_e[1]), .out_last(out_l[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Words a request must produce, from value ranges and field placement
    function automatic void model(input logic [31:0] imm, input logic [4:0] ope, input logic [31:0] base,
                                  input logic split, input logic split_en,
                                  output int n, output logic [33:0] w0, output logic [33:0] w1);
        logic [31:0] inst;
        logic [31:0] upper;
        logic [4:0]  rd;
        longint      s;
        bit          ok;
        s    = longint'($signed(imm));
        inst = base;
        ok   = 1'b1;
        case (ope)
            `IMM_I: begin
                inst[31:20] = imm[11:0];
                ok = (s >= -2048) && (s <= 2047);
            end
            `IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                ok = (s >= -2048) && (s <= 2047);
            end
            `IMM_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                ok = (s % 2 == 0) && (s >= -4096) && (s <= 4095);
            end
            `IMM_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                ok = (s % 2 == 0) && (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20));
            end
            `IMM_U: begin
                inst[31:12] = imm[31:12];
                ok = (imm % 4096) == 0;
            end
            default: ok = 1'b0;
        endcase
        n  = 1;
        w0 = {inst, !ok, 1'b1};
        w1 = 34'd0;
        if (ope == `IMM_I && !ok && split && split_en) begin
            upper = (imm + 32'h800) >> 12;
            rd    = base[11:7];
            n  = 2;
            w0 = {upper[19:0], rd, 7'h37, 1'b0, 1'b0};
            w1 = {imm[11:0], rd, 3'b000, rd, 7'h13, 1'b0, 1'b1};
        end
    endfunction

    // Model update on each edge: pop on output handshake, push on accept
    initial begin
        cnt[0] = 0;
        cnt[1] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cnt[0] = 0;
                cnt[1] = 0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    bit          rdy;
                    bit          vld;
                    int          n;
                    logic [33:0] w0, w1;
                    rdy = (cnt[k] == 0) || (cnt[k] == 1 && out_ready);
                    vld = (k == 0) ? in_valid_a : in_valid_b;
                    if (cnt[k] > 0 && out_ready) begin
                        q[k][0] = q[k][1];
                        cnt[k]--;
                    end
                    if (vld && rdy) begin
                        model(in_imm, in_sext_ope, in_base, in_split, (k == 0), n, w0, w1);
                        q[k][cnt[k]] = w0;
                        if (n == 2) q[k][cnt[k] + 1] = w1;
                        cnt[k] += n;
                    end
                end
            end
        end
    end

    // Compare both instances against the model every falling edge
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit exp_rdy;
                exp_rdy = (cnt[k] == 0) || (cnt[k] == 1 && out_ready);
                chk($sformatf("dut%0d.out_valid", k), {31'd0, out_vld[k]}, {31'd0, cnt[k] > 0});
                chk($sformatf("dut%0d.in_ready", k), {31'd0, in_rdy[k]}, {31'd0, exp_rdy});
                if (cnt[k] > 0) begin
                    chk($sformatf("dut%0d.out_inst", k), out_inst[k], q[k][0][33:2]);
                    chk($sformatf("dut%0d.out_err", k), {31'd0, out_e[k]}, {31'd0, q[k][0][1]});
                    chk($sformatf("dut%0d.out_last", k), {31'd0, out_l[k]}, {31'd0, q[k][0][0]});
                end
            end
        end
    end

    // Random consumer backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present a request to instance k and return 1 time unit after the accepting edge
    task automatic send(input int k, input logic [31:0] imm, input logic [4:0] ope,
                        input logic [31:0] base, input logic split);
        bit acc;
        acc         = 1'b0;
        in_imm      = imm;
        in_sext_ope = ope;
        in_base     = base;
        in_split    = split;
        if (k == 0) in_valid_a = 1'b1;
        else        in_valid_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_rdy[k]) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    logic [31:0] tv_imm  [14] = '{32'h000007FF, 32'h00000800, 32'hFFFFF000, 32'h00001000,
                                  32'hFFF00000, 32'h00100000, 32'h00000005, 32'h00000000,
                                  32'h80000000, 32'h00000800, 32'hABCDE123, 32'h00000000,
                                  32'h7FFFF800, 32'hFFFFF800};
    logic [4:0]  tv_ope  [14] = '{`IMM_I, `IMM_S, `IMM_B, `IMM_B, `IMM_J, `IMM_J, `IMM_J, `IMM_U,
                                  `IMM_I, `IMM_I, `IMM_I, 5'd31, `IMM_I, `IMM_I};
    logic [31:0] tv_base [14] = '{32'hFFFFFFFF, 32'h00002023, 32'h00000063, 32'h00000063,
                                  32'h0000006F, 32'h0000006F, 32'h000000EF, 32'hFFFFFFFF,
                                  32'h00000513, 32'h00000513, 32'h00000F93, 32'h12345678,
                                  32'h00000113, 32'h00000113};
    logic        tv_spl  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int          n;
        logic [33:0] w0, w1;

        // model pins
        model(32'h12345FFF, `IMM_I, 32'h00000293, 1'b1, 1'b1, n, w0, w1);
        chk("pin_lui", w0[33:2], 32'h123462B7);
        chk("pin_addi", w1[33:2], 32'hFFF28293);
        model(32'h00000FFE, `IMM_B, 32'h00000063, 1'b0, 1'b1, n, w0, w1);
        chk("pin_b", w0[33:2], 32'h7E000FE3);

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_vld[0]}, 32'd0);
        chk("rst_out_inst", out_inst[0], 32'd0);
        chk("rst_out_err", {31'd0, out_e[0]}, 32'd0);
        chk("rst_out_last", {31'd0, out_l[0]}, 32'd0);
        #21 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_rdy[0]}, 32'd1);
        @(posedge clk);
        #1;

        // I-type at the negative boundary
        send(0, 32'hFFFFF800, `IMM_I, 32'h00000093, 1'b0);
        chk("i_neg_inst", out_inst[0], 32'h80000093);
        chk("i_neg_err", {31'd0, out_e[0]}, 32'd0);
        chk("i_neg_last", {31'd0, out_l[0]}, 32'd1);

        // B-type and U-type range checks
        send(0, 32'h00000FFE, `IMM_B, 32'h00000063, 1'b0);
        chk("b_max_inst", out_inst[0], 32'h7E000FE3);
        chk("b_max_err", {31'd0, out_e[0]}, 32'd0);
        send(0, 32'h00000003, `IMM_B, 32'h00000063, 1'b0);
        chk("b_odd_err", {31'd0, out_e[0]}, 32'd1);
        send(0, 32'h00001001, `IMM_U, 32'h00000037, 1'b0);
        chk("u_low_err", {31'd0, out_e[0]}, 32'd1);
        send(0, 32'h00000000, `IMM_B, 32'hFFFFFFFF, 1'b0);
        chk("b_zero_inst", out_inst[0], 32'h01FFF07F);
        send(0, 32'hDEADBEEF, 5'd31, 32'hDEADBEEF, 1'b0);
        chk("unk_inst", out_inst[0], 32'hDEADBEEF);
        chk("unk_err", {31'd0, out_e[0]}, 32'd1);

        // LUI+ADDI expansion
        send(0, 32'h12345FFF, `IMM_I, 32'h00000293, 1'b1);
        chk("split_lui", out_inst[0], 32'h123462B7);
        chk("split_lui_last", {31'd0, out_l[0]}, 32'd0);
        chk("split_hi_rdy", {31'd0, in_rdy[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("split_addi", out_inst[0], 32'hFFF28293);
        chk("split_addi_last", {31'd0, out_l[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("split_done", {31'd0, out_vld[0]}, 32'd0);

        // same request with expansion disabled
        send(1, 32'h12345FFF, `IMM_I, 32'h00000293, 1'b1);
        chk("nosplit_inst", out_inst[1], 32'hFFF00293);
        chk("nosplit_err", {31'd0, out_e[1]}, 32'd1);
        chk("nosplit_last", {31'd0, out_l[1]}, 32'd1);
        @(posedge clk);
        #1;

        // stall with word held, next request waiting, then same-edge consume and accept
        out_ready = 1'b0;
        send(0, 32'h000007FF, `IMM_S, 32'h00A12023, 1'b0);
        in_imm      = 32'h00000800;
        in_sext_ope = `IMM_J;
        in_base     = 32'h000000EF;
        in_split    = 1'b0;
        in_valid_a  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_inst", out_inst[0], 32'h7EA12FA3);
            chk("stall_rdy", {31'd0, in_rdy[0]}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        chk("b2b_inst", out_inst[0], 32'h001000EF);
        chk("b2b_err", {31'd0, out_e[0]}, 32'd0);
        @(posedge clk);
        #1;

        // table sweep, consumer always ready
        for (int i = 0; i < 14; i++) send(0, tv_imm[i], tv_ope[i], tv_base[i], tv_spl[i]);
        repeat (3) @(posedge clk);
        #1;

        // table sweep under random backpressure, both instances
        rand_rdy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(0, tv_imm[i], tv_ope[i], tv_base[i], tv_spl[i]);
            send(1, tv_imm[i], tv_ope[i], tv_base[i], tv_spl[i]);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // reset while LUI is held: ADDI must never appear
        out_ready = 1'b0;
        send(0, 32'h12345FFF, `IMM_I, 32'h00000293, 1'b1);
        chk("rst_hi_lui", out_inst[0], 32'h123462B7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hi_valid", {31'd0, out_vld[0]}, 32'd0);
        chk("rst_hi_inst", out_inst[0], 32'd0);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_hi_rdy", {31'd0, in_rdy[0]}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi_no_addi", {31'd0, out_vld[0]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
